// File: rtl/address_bus_interface_if.sv
// address_bus_interface_if
//   External memory handshake between the CPU bus interface and the memory.
//   One access per CPU cycle. Each access ends with a single-clock mem_ready.
//
//   mem_addr   16  access address {ABH,ABL}           (master -> slave)
//   mem_wdata   8  write data (DOR)                   (master -> slave)
//   mem_req     1  access outstanding                 (master -> slave)
//   mem_we      1  1 = write access                   (master -> slave)
//   mem_rdata   8  read data, valid with mem_ready    (slave -> master)
//   mem_ready   1  access completes this clock        (slave -> master)
interface address_bus_interface_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_req,
    output mem_we,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_req,
    input  mem_we,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/address_bus_interface.sv
// address_bus_interface
//   Memory-side end of the internal ADL/ADH address buses and the data bus.
//   On phase_1_rising the block latches the address registers ABL/ABH and the
//   data output register DOR, and then runs one external access. Read data is
//   captured in the data latch DL, and DL can be driven back onto the
//   internal buses.
//
//   Ports:
//     sys_clock, reset         clock, synchronous active-high reset
//     phase_1_rising           start-of-CPU-cycle strobe (one clock)
//     phase_2_rising           phase 2 strobe (one clock)
//     adl_abl / adh_abh        load ABL / ABH at phase_1_rising
//     db_dor                   load DOR from data_bus at phase_1_rising
//     rw                       1 = read, 0 = write (sampled at phase_1_rising)
//     dl_db / dl_adl / dl_adh  drive DL onto data_bus / address_l / address_h
//     address_l, address_h     internal ADL / ADH buses (tri-state)
//     data_bus                 internal data bus (tri-state)
//     mem_bus                  memory handshake (master side)
//     cpu_ready                low while an access is outstanding
//     bus_error                sticky access-timeout flag
module address_bus_interface #(
  parameter logic [15:0] ABR_RESET_ADDR = 16'h0000,
  parameter int unsigned WAIT_LIMIT     = 8
) (
  input  logic                           sys_clock,
  input  logic                           reset,
  input  logic                           phase_1_rising,
  input  logic                           phase_2_rising,
  input  logic                           adl_abl,
  input  logic                           adh_abh,
  input  logic                           db_dor,
  input  logic                           rw,
  input  logic                           dl_db,
  input  logic                           dl_adl,
  input  logic                           dl_adh,
  inout  wire  [7:0]                     address_l,
  inout  wire  [7:0]                     address_h,
  inout  wire  [7:0]                     data_bus,
  address_bus_interface_if.master        mem_bus,
  output logic                           cpu_ready,
  output logic                           bus_error
);

  // The counter only has to reach WAIT_LIMIT-1. With WAIT_LIMIT=0 it simply
  // wraps, because the timeout compare is disabled.
  localparam int unsigned CNT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  state_t            state_q;
  logic [7:0]        abl_q;
  logic [7:0]        abh_q;
  logic [7:0]        dor_q;
  logic [7:0]        dl_q;
  logic              mem_we_q;
  logic              bus_error_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_d;
  logic              timeout_hit;

  always_comb begin
    wait_cnt_d  = wait_cnt_q + CNT_W'(1);
    timeout_hit = (WAIT_LIMIT != 0) && (wait_cnt_q == LAST_CNT);
  end

  // The whole controller is one registered FSM. Register loads happen only
  // on the transition into ACCESS, so the address, write data and direction
  // cannot change while an access is outstanding.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      abl_q       <= ABR_RESET_ADDR[7:0];
      abh_q       <= ABR_RESET_ADDR[15:8];
      dor_q       <= '0;
      dl_q        <= '0;
      mem_we_q    <= 1'b0;
      bus_error_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_COMPLETE: begin
          // phase_1 outranks phase_2 when both arrive together. A phase_1 seen
          // in COMPLETE means phase 2 was skipped, and it starts a new cycle.
          if (phase_1_rising) begin
            if (adl_abl) abl_q <= address_l;
            if (adh_abh) abh_q <= address_h;
            if (db_dor)  dor_q <= data_bus;
            mem_we_q   <= ~rw;
            wait_cnt_q <= '0;
            state_q    <= ST_ACCESS;
          end else if ((state_q == ST_COMPLETE) && phase_2_rising) begin
            state_q <= ST_IDLE;
          end
        end

        ST_ACCESS: begin
          // mem_ready takes priority over the timeout in the same clock.
          if (mem_bus.mem_ready) begin
            if (!mem_we_q) dl_q <= mem_bus.mem_rdata;
            state_q <= ST_COMPLETE;
          end else if (timeout_hit) begin
            if (!mem_we_q) dl_q <= 8'hFF;
            bus_error_q <= 1'b1;
            state_q     <= ST_COMPLETE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The handshake outputs are decoded from the registered state only.
  assign mem_bus.mem_req   = (state_q == ST_ACCESS);
  assign mem_bus.mem_we    = mem_we_q;
  assign mem_bus.mem_addr  = {abh_q, abl_q};
  assign mem_bus.mem_wdata = dor_q;
  assign cpu_ready         = (state_q != ST_ACCESS);
  assign bus_error         = bus_error_q;

  // DL is the only value this block ever puts on the internal buses.
  assign data_bus  = dl_db  ? dl_q : 'z;
  assign address_l = dl_adl ? dl_q : 'z;
  assign address_h = dl_adh ? dl_q : 'z;

  a_reset_drops_req : assert property (
    @(posedge sys_clock) reset |=> !mem_bus.mem_req
  );

  a_access_stable : assert property (
    @(posedge sys_clock) disable iff (reset)
      (state_q == ST_ACCESS) |=> ($stable(mem_bus.mem_addr) &&
                                  $stable(mem_bus.mem_we) &&
                                  $stable(mem_bus.mem_wdata))
  );

endmodule

// File: tb/tb_address_bus_interface.sv
module tb_address_bus_interface;
  localparam int WL = 8;

  logic sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  logic reset, phase_1_rising, phase_2_rising, adl_abl, adh_abh, db_dor, rw;
  logic dl_db, dl_adl, dl_adh;
  logic cpu_ready, bus_error;

  logic [7:0] drv_l, drv_h, drv_db;
  logic       drv_l_en, drv_h_en, drv_db_en;
  wire  [7:0] address_l, address_h, data_bus;
  assign address_l = drv_l_en  ? drv_l  : 'z;
  assign address_h = drv_h_en  ? drv_h  : 'z;
  assign data_bus  = drv_db_en ? drv_db : 'z;

  address_bus_interface_if mem_if();

  address_bus_interface #(
    .ABR_RESET_ADDR(16'hFFFC),
    .WAIT_LIMIT(WL)
  ) dut (
    .sys_clock(sys_clock), .reset(reset),
    .phase_1_rising(phase_1_rising), .phase_2_rising(phase_2_rising),
    .adl_abl(adl_abl), .adh_abh(adh_abh), .db_dor(db_dor), .rw(rw),
    .dl_db(dl_db), .dl_adl(dl_adl), .dl_adh(dl_adh),
    .address_l(address_l), .address_h(address_h), .data_bus(data_bus),
    .mem_bus(mem_if), .cpu_ready(cpu_ready), .bus_error(bus_error)
  );

  int unsigned tests_run = 0;
  int unsigned failed = 0;

  // Architectural model: register contents and sticky error
  logic [7:0] m_abl, m_abh, m_dor, m_dl;
  logic       m_err;

  task automatic clk();
    @(posedge sys_clock); #1;
  endtask

  task automatic model_reset();
    m_abl = 8'hFC; m_abh = 8'hFF; m_dor = 8'h00; m_dl = 8'h00; m_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; clk(); reset = 1'b0; model_reset();
  endtask

  task automatic start_cycle(input logic sl, input logic sh, input logic sd, input logic rd,
                             input logic [7:0] al, input logic [7:0] ah, input logic [7:0] d);
    drv_l = al; drv_h = ah; drv_db = d;
    drv_l_en = 1'b1; drv_h_en = 1'b1; drv_db_en = 1'b1;
    adl_abl = sl; adh_abh = sh; db_dor = sd; rw = rd;
    phase_1_rising = 1'b1;
    clk();
    phase_1_rising = 1'b0; adl_abl = 1'b0; adh_abh = 1'b0; db_dor = 1'b0;
    drv_l_en = 1'b0; drv_h_en = 1'b0; drv_db_en = 1'b0;
    if (sl) m_abl = al;
    if (sh) m_abh = ah;
    if (sd) m_dor = d;
  endtask

  // Answer the access after 'delay' waiting clocks (delay<0: never).
  task automatic run_access(input int delay, input logic [7:0] rdata,
                            output int clocks, output logic stable);
    logic [15:0] a0; logic [7:0] w0; logic we0;
    a0 = mem_if.mem_addr; w0 = mem_if.mem_wdata; we0 = mem_if.mem_we;
    clocks = 0; stable = 1'b1;
    while (mem_if.mem_req === 1'b1 && clocks < 64) begin
      if (mem_if.mem_addr !== a0 || mem_if.mem_wdata !== w0 ||
          mem_if.mem_we !== we0 || cpu_ready !== 1'b0) stable = 1'b0;
      mem_if.mem_ready = (clocks == delay);
      mem_if.mem_rdata = (clocks == delay) ? rdata : 8'($urandom);
      clk();
      clocks++;
    end
    mem_if.mem_ready = 1'b0;
  endtask

  // Access outcome from the protocol rules: answered within the limit or aborted.
  task automatic model_access(input logic rd, input int delay, input logic [7:0] rdata,
                              output int exp_clocks);
    if (delay < 0 || delay >= WL) begin
      exp_clocks = WL;
      if (rd) m_dl = 8'hFF;
      m_err = 1'b1;
    end else begin
      exp_clocks = delay + 1;
      if (rd) m_dl = rdata;
    end
  endtask

  task automatic read_dl(output logic [7:0] v);
    dl_db = 1'b1; #1; v = data_bus; dl_db = 1'b0; #1;
  endtask

  task automatic phase2();
    phase_2_rising = 1'b1; clk(); phase_2_rising = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    // Reset must win over a simultaneous phase_1 strobe
    reset = 1'b1; phase_1_rising = 1'b1; adl_abl = 1'b1; adh_abh = 1'b1;
    drv_l = 8'h11; drv_h = 8'h22; drv_l_en = 1'b1; drv_h_en = 1'b1;
    clk();
    phase_1_rising = 1'b0; adl_abl = 1'b0; adh_abh = 1'b0;
    drv_l_en = 1'b0; drv_h_en = 1'b0;
    reset = 1'b0; model_reset();
    tests_run++; if (mem_if.mem_addr !== 16'hFFFC) begin failed++; $display("FAIL reset_addr: got %h want fffc", mem_if.mem_addr); end
    tests_run++; if (mem_if.mem_req !== 1'b0) begin failed++; $display("FAIL reset_req: got %b want 0", mem_if.mem_req); end
    tests_run++; if (cpu_ready !== 1'b1) begin failed++; $display("FAIL reset_cpu_ready: got %b want 1", cpu_ready); end
    tests_run++; if (bus_error !== 1'b0) begin failed++; $display("FAIL reset_bus_error: got %b want 0", bus_error); end
    tests_run++; if (mem_if.mem_we !== 1'b0) begin failed++; $display("FAIL reset_we: got %b want 0", mem_if.mem_we); end
    tests_run++; if (mem_if.mem_wdata !== 8'h00) begin failed++; $display("FAIL reset_dor: got %h want 00", mem_if.mem_wdata); end
    read_dl(v);
    tests_run++; if (v !== 8'h00) begin failed++; $display("FAIL reset_dl: got %h want 00", v); end
  endtask

  task automatic test_read();
    int c; logic st; logic [7:0] v;
    start_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h34, 8'h12, 8'h00);
    tests_run++; if (mem_if.mem_addr !== 16'h1234) begin failed++; $display("FAIL read_addr: got %h want 1234", mem_if.mem_addr); end
    tests_run++; if (mem_if.mem_we !== 1'b0) begin failed++; $display("FAIL read_we: got %b want 0", mem_if.mem_we); end
    run_access(3, 8'hA9, c, st);
    tests_run++; if (c != 4) begin failed++; $display("FAIL read_busy_clocks: got %0d want 4", c); end
    tests_run++; if (st !== 1'b1) begin failed++; $display("FAIL read_stable: got %b want 1", st); end
    m_dl = 8'hA9;
    read_dl(v);
    tests_run++; if (v !== 8'hA9) begin failed++; $display("FAIL read_dl: got %h want a9", v); end
    phase2();
    tests_run++; if (cpu_ready !== 1'b1 || mem_if.mem_req !== 1'b0) begin failed++; $display("FAIL read_idle: got rdy=%b req=%b want 1/0", cpu_ready, mem_if.mem_req); end
  endtask

  task automatic test_write();
    int c; logic st; logic [7:0] v;
    start_cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 8'h77, 8'h5A);
    tests_run++; if (mem_if.mem_we !== 1'b1) begin failed++; $display("FAIL write_we: got %b want 1", mem_if.mem_we); end
    tests_run++; if (mem_if.mem_wdata !== 8'h5A) begin failed++; $display("FAIL write_wdata: got %h want 5a", mem_if.mem_wdata); end
    tests_run++; if (mem_if.mem_addr !== 16'h1280) begin failed++; $display("FAIL write_addr: got %h want 1280", mem_if.mem_addr); end
    run_access(1, 8'h33, c, st);
    tests_run++; if (c != 2 || st !== 1'b1) begin failed++; $display("FAIL write_access: got clocks=%0d stable=%b want 2/1", c, st); end
    read_dl(v);
    tests_run++; if (v !== 8'hA9) begin failed++; $display("FAIL write_dl_hold: got %h want a9", v); end
    phase2();
  endtask

  task automatic test_timeout();
    int c; logic st; logic [7:0] v;
    start_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h30, 8'h20, 8'h00);
    run_access(-1, 8'h00, c, st);
    tests_run++; if (c != WL) begin failed++; $display("FAIL timeout_req_clocks: got %0d want %0d", c, WL); end
    read_dl(v);
    tests_run++; if (v !== 8'hFF) begin failed++; $display("FAIL timeout_dl: got %h want ff", v); end
    tests_run++; if (bus_error !== 1'b1) begin failed++; $display("FAIL timeout_err: got %b want 1", bus_error); end
    phase2();
    start_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h31, 8'h00, 8'h00);
    run_access(0, 8'h3C, c, st);
    read_dl(v);
    tests_run++; if (v !== 8'h3C) begin failed++; $display("FAIL post_timeout_dl: got %h want 3c", v); end
    tests_run++; if (bus_error !== 1'b1) begin failed++; $display("FAIL err_sticky: got %b want 1", bus_error); end
    phase2();
    do_reset();
    tests_run++; if (bus_error !== 1'b0) begin failed++; $display("FAIL err_reset_clear: got %b want 0", bus_error); end
  endtask

  task automatic test_ready_last();
    int c; logic st; logic [7:0] v;
    start_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 8'h40, 8'h00);
    run_access(WL - 1, 8'h6E, c, st);
    m_dl = 8'h6E;
    tests_run++; if (c != WL) begin failed++; $display("FAIL last_clock_req: got %0d want %0d", c, WL); end
    tests_run++; if (bus_error !== 1'b0) begin failed++; $display("FAIL last_clock_err: got %b want 0", bus_error); end
    read_dl(v);
    tests_run++; if (v !== 8'h6E) begin failed++; $display("FAIL last_clock_dl: got %h want 6e", v); end
    phase2();
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] v;
    start_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 8'h44, 8'h00);
    mem_if.mem_ready = 1'b0; clk();
    reset = 1'b1; clk(); reset = 1'b0; model_reset();
    tests_run++; if (mem_if.mem_req !== 1'b0 || cpu_ready !== 1'b1) begin failed++; $display("FAIL midreset_req: got req=%b rdy=%b want 0/1", mem_if.mem_req, cpu_ready); end
    tests_run++; if (mem_if.mem_addr !== 16'hFFFC) begin failed++; $display("FAIL midreset_addr: got %h want fffc", mem_if.mem_addr); end
    clk();
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 8'h77; clk(); mem_if.mem_ready = 1'b0;
    read_dl(v);
    tests_run++; if (v !== 8'h00) begin failed++; $display("FAIL late_ready_dl: got %h want 00", v); end
    tests_run++; if (mem_if.mem_req !== 1'b0) begin failed++; $display("FAIL late_ready_req: got %b want 0", mem_if.mem_req); end
  endtask

  task automatic test_p1_in_complete();
    int c; logic st; logic [7:0] v;
    start_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hEF, 8'hBE, 8'h00);
    run_access(2, 8'h42, c, st);
    start_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hFE, 8'hCA, 8'h00);
    tests_run++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'hCAFE) begin failed++; $display("FAIL skip_p2_restart: got req=%b addr=%h want 1/cafe", mem_if.mem_req, mem_if.mem_addr); end
    run_access(0, 8'h99, c, st);
    read_dl(v);
    tests_run++; if (v !== 8'h99 || c != 1) begin failed++; $display("FAIL skip_p2_dl: got %h/%0d want 99/1", v, c); end
    phase2();
    // phase_1 and phase_2 together in COMPLETE: only phase_1 counts
    start_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 8'h01, 8'h00);
    run_access(0, 8'h10, c, st);
    phase_2_rising = 1'b1;
    start_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 8'h03, 8'h00);
    phase_2_rising = 1'b0;
    tests_run++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h0304) begin failed++; $display("FAIL both_phases: got req=%b addr=%h want 1/0304", mem_if.mem_req, mem_if.mem_addr); end
    run_access(0, 8'h20, c, st);
    m_dl = 8'h20;
    phase2();
  endtask

  task automatic test_phase_ignored_in_access();
    int c; logic st; logic [7:0] v;
    start_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 8'h55, 8'h00);
    drv_l = 8'hAA; drv_h = 8'hAA; drv_l_en = 1'b1; drv_h_en = 1'b1;
    adl_abl = 1'b1; adh_abh = 1'b1; phase_1_rising = 1'b1; clk();
    phase_1_rising = 1'b0; phase_2_rising = 1'b1; clk(); phase_2_rising = 1'b0;
    adl_abl = 1'b0; adh_abh = 1'b0; drv_l_en = 1'b0; drv_h_en = 1'b0;
    tests_run++; if (mem_if.mem_addr !== 16'h5566 || mem_if.mem_req !== 1'b1) begin failed++; $display("FAIL access_ignores_phase: got addr=%h req=%b want 5566/1", mem_if.mem_addr, mem_if.mem_req); end
    run_access(0, 8'hC3, c, st);
    m_dl = 8'hC3;
    read_dl(v);
    tests_run++; if (v !== 8'hC3) begin failed++; $display("FAIL access_ignores_phase_dl: got %h want c3", v); end
    phase2();
  endtask

  // DL = C3 here. The bench drives 00 on the bus that must be released, so any
  // stray DUT drive corrupts the value read.
  task automatic test_bus_drive();
    drv_h = 8'h00; drv_db = 8'h00; drv_h_en = 1'b1; drv_db_en = 1'b1;
    dl_adl = 1'b1; #1;
    tests_run++; if (address_l !== 8'hC3 || address_h !== 8'h00 || data_bus !== 8'h00) begin failed++; $display("FAIL dl_adl_drive: got l=%h h=%h db=%h want c3/00/00", address_l, address_h, data_bus); end
    dl_adl = 1'b0; drv_h_en = 1'b0;
    drv_l = 8'h00; drv_l_en = 1'b1;
    dl_adh = 1'b1; #1;
    tests_run++; if (address_h !== 8'hC3 || address_l !== 8'h00 || data_bus !== 8'h00) begin failed++; $display("FAIL dl_adh_drive: got l=%h h=%h db=%h want 00/c3/00", address_l, address_h, data_bus); end
    dl_adh = 1'b0; drv_h_en = 1'b1; #1;
    tests_run++; if (address_h !== 8'h00 || address_l !== 8'h00 || data_bus !== 8'h00) begin failed++; $display("FAIL buses_released: got l=%h h=%h db=%h want 00/00/00", address_l, address_h, data_bus); end
    drv_l_en = 1'b0; drv_h_en = 1'b0; drv_db_en = 1'b0;
    clk();
  endtask

  task automatic test_random();
    int c, ec, delay; logic st; logic [7:0] v, al, ah, d, rdata; logic sl, sh, sd, rd;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_reset();
        tests_run++; if (mem_if.mem_addr !== 16'hFFFC || bus_error !== 1'b0) begin failed++; $display("FAIL rand_reset[%0d]: got addr=%h err=%b want fffc/0", i, mem_if.mem_addr, bus_error); end
      end
      sl = 1'($urandom); sh = 1'($urandom); sd = 1'($urandom); rd = 1'($urandom);
      al = 8'($urandom); ah = 8'($urandom); d = 8'($urandom); rdata = 8'($urandom);
      delay = $urandom_range(0, 11);
      if (delay >= 10) delay = -1;
      start_cycle(sl, sh, sd, rd, al, ah, d);
      tests_run++; if (mem_if.mem_addr !== {m_abh, m_abl} || mem_if.mem_we !== ~rd || mem_if.mem_wdata !== m_dor || mem_if.mem_req !== 1'b1) begin failed++; $display("FAIL rand_launch[%0d]: got addr=%h we=%b wd=%h req=%b want %h/%b/%h/1", i, mem_if.mem_addr, mem_if.mem_we, mem_if.mem_wdata, mem_if.mem_req, {m_abh, m_abl}, ~rd, m_dor); end
      run_access(delay, rdata, c, st);
      model_access(rd, delay, rdata, ec);
      tests_run++; if (c != ec || st !== 1'b1) begin failed++; $display("FAIL rand_access[%0d]: got clocks=%0d stable=%b want %0d/1", i, c, st, ec); end
      read_dl(v);
      tests_run++; if (v !== m_dl || bus_error !== m_err) begin failed++; $display("FAIL rand_result[%0d]: got dl=%h err=%b want %h/%b", i, v, bus_error, m_dl, m_err); end
      if (1'($urandom)) phase2();
      tests_run++; if (cpu_ready !== 1'b1) begin failed++; $display("FAIL rand_cpu_ready[%0d]: got %b want 1", i, cpu_ready); end
    end
  endtask

  initial begin
    reset = 1'b1; phase_1_rising = 1'b0; phase_2_rising = 1'b0;
    adl_abl = 1'b0; adh_abh = 1'b0; db_dor = 1'b0; rw = 1'b1;
    dl_db = 1'b0; dl_adl = 1'b0; dl_adh = 1'b0;
    drv_l = '0; drv_h = '0; drv_db = '0;
    drv_l_en = 1'b0; drv_h_en = 1'b0; drv_db_en = 1'b0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = '0;
    model_reset();
    clk();
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_ready_last();
    test_reset_mid_access();
    test_p1_in_complete();
    test_phase_ignored_in_access();
    test_bus_drive();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/address_bus_interface.md
Name: address_bus_interface

Overview:
- Memory-side end of the internal ADL/ADH address buses and the internal data bus.
- Latches the address buses into the address bus registers ABL/ABH on the phase 1 strobe.
- Runs one external memory read or write per CPU cycle using a req/ready handshake.
- Captures read data into the data latch DL, holds write data in the data output register DOR, and drives DL back onto the internal buses on command.

Parameters:
ABR_RESET_ADDR, 16'h0000, value of {ABH,ABL} after reset
WAIT_LIMIT, 8, max sys_clock cycles spent in ACCESS before abort; 0 = no timeout

Ports:
sys_clock  input  1  system clock
reset  input  1  synchronous, active-high reset
phase_1_rising  input  1  one-clock pulse at start of CPU cycle
phase_2_rising  input  1  one-clock pulse at phase 2 start
adl_abl  input  1  load ABL from address_l at phase_1_rising
adh_abh  input  1  load ABH from address_h at phase_1_rising
db_dor  input  1  load DOR from data_bus at phase_1_rising
rw  input  1  1 = read, 0 = write; sampled at phase_1_rising
dl_db  input  1  drive DL onto data_bus
dl_adl  input  1  drive DL onto address_l
dl_adh  input  1  drive DL onto address_h
address_l  inout  8  internal ADL bus
address_h  inout  8  internal ADH bus
data_bus  inout  8  internal data bus
mem_addr  output  16  {ABH,ABL}
mem_wdata  output  8  DOR
mem_req  output  1  access request
mem_we  output  1  1 = write access
mem_rdata  input  8  read data, valid when mem_ready=1
mem_ready  input  1  access complete this clock
cpu_ready  output  1  0 while an access is outstanding (RDY to timing generator)
bus_error  output  1  sticky timeout flag

Behaviour:
- Reset values:
  - {ABH,ABL}=ABR_RESET_ADDR; DOR=0; DL=0.
  - mem_req=0, mem_we=0, bus_error=0, cpu_ready=1.
  - Wait counter=0; state IDLE.
- Reset dominates all other inputs in the same clock.
- Reset mid-ACCESS: mem_req low on the next clock; a late mem_ready is ignored.
- States: IDLE, ACCESS, COMPLETE.
- IDLE or COMPLETE, phase_1_rising:
  - Same clock: ABL<=address_l if adl_abl; ABH<=address_h if adh_abh; DOR<=data_bus if db_dor; mem_we<=~rw.
  - Unselected registers hold.
  - Next state ACCESS; wait counter cleared.
  - A phase_1_rising in COMPLETE means phase 2 was skipped; treat it as a normal new cycle.
- ACCESS:
  - mem_req=1; cpu_ready=0 (combinational from state).
  - mem_addr, mem_we, mem_wdata are stable for the whole access.
  - mem_ready=1: on a read, DL<=mem_rdata; on a write, DL holds. Go to COMPLETE; mem_req is 0 from the next clock.
  - Otherwise the wait counter increments.
  - WAIT_LIMIT>0 and counter reaches WAIT_LIMIT-1 without mem_ready: abort. DL<=8'hFF on a read, bus_error<=1, go to COMPLETE.
  - mem_ready in the abort clock wins: normal completion, no error.
  - phase_1_rising and phase_2_rising are ignored in ACCESS; the timing generator must stretch the phase while cpu_ready=0.
- COMPLETE: phase_2_rising -> IDLE. DL and ABx hold until the next phase_1_rising.
- phase_1_rising and phase_2_rising in the same clock is illegal; treat it as phase_1_rising only.
- Minimum access: mem_req high for 1 clock if mem_ready is already high in the first ACCESS clock.
- bus_error clears only on reset.
- Tri-state outputs are combinational and not registered:
  - data_bus = dl_db ? DL : Z.
  - address_l = dl_adl ? DL : Z.
  - address_h = dl_adh ? DL : Z.
- The block never drives data_bus or address buses otherwise. Contention with other drivers is a control-logic error and is not checked here.
- mem_addr={ABH,ABL} and mem_wdata=DOR are continuous.

Test Plan:
- Reset with ABR_RESET_ADDR=16'hFFFC -> mem_addr=16'hFFFC, mem_req=0, cpu_ready=1, bus_error=0, DL reads 8'h00 via dl_db.
- Read: address_l=8'h34, address_h=8'h12, adl_abl=adh_abh=1, rw=1, phase_1_rising; mem_ready after 3 clocks with mem_rdata=8'hA9.
  - mem_addr=16'h1234, mem_we=0, cpu_ready low exactly 4 clocks.
  - After completion, dl_db puts 8'hA9 on data_bus; phase_2_rising returns to IDLE.
- Write: data_bus=8'h5A, db_dor=1, rw=0, adl_abl only with address_l=8'h80.
  - mem_we=1, mem_wdata=8'h5A, mem_addr=16'h1280 (ABH held), DL unchanged.
- Timeout with WAIT_LIMIT=8 and no mem_ready, read:
  - mem_req high exactly 8 clocks, then DL=8'hFF, bus_error=1.
  - bus_error persists through the next successful cycle until reset.
- Boundaries:
  - mem_ready in the 8th ACCESS clock -> normal completion, bus_error=0.
  - Reset asserted during ACCESS -> mem_req=0 next clock; mem_ready 2 clocks later leaves DL=0.
  - phase_1_rising in COMPLETE without phase_2 -> new access starts with newly latched address.
  - dl_adl/dl_adh drive DL onto address_l/address_h only while asserted; Z otherwise.
